cache_control: RTL and testbench

//  Control FSM for the direct-mapped write-back cache. It sequences the tag, valid,

---
 rtl/cache_control.sv | 126 ++++++++++++
 tb/tb_cache_control.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_control.sv
// Decision FSM for a direct-mapped write-back cache: sequences the tag/valid/dirty/data
// arrays, handshakes with CPU and physical memory, and keeps saturating hit/miss counters.
module cache_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             hit,
  input  logic             valid_out,
  input  logic             dirty_out,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output logic             pmem_addr_sel,
  output logic             data_sel,
  output logic             load_data,
  output logic             load_tag,
  output logic             load_valid,
  output logic             load_dirty,
  output logic             dirty_in,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TAG_CHECK = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             refill_q, refill_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic             req;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A simultaneous read and write is serviced as a write, so only mem_write matters below.
  assign req = mem_read | mem_write;

  always_comb begin
    state_d       = state_q;
    refill_d      = refill_q;
    hit_d         = hit_q;
    miss_d        = miss_q;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    data_sel      = 1'b0;
    load_data     = 1'b0;
    load_tag      = 1'b0;
    load_valid    = 1'b0;
    load_dirty    = 1'b0;
    dirty_in      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) state_d = TAG_CHECK;
      end
      TAG_CHECK: begin
        if (!req) begin
          state_d  = IDLE;
          refill_d = 1'b0;
        end else if (hit) begin
          mem_resp = 1'b1;
          state_d  = IDLE;
          refill_d = 1'b0;
          if (mem_write) begin
            load_data  = 1'b1;
            load_dirty = 1'b1;
            dirty_in   = 1'b1;
          end
          // The retry after a fill always hits; it must not be scored as a hit.
          if (!refill_q) hit_d = sat_inc(hit_q);
        end else begin
          miss_d  = sat_inc(miss_q);
          state_d = (valid_out && dirty_out) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        if (pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          load_data  = 1'b1;
          data_sel   = 1'b1;
          load_tag   = 1'b1;
          load_valid = 1'b1;
          load_dirty = 1'b1;
          refill_d   = 1'b1;
          state_d    = TAG_CHECK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces IDLE asynchronously, which zeroes every decoded output at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      refill_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      refill_q <= refill_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: emulated tag/valid/dirty arrays and memory responder, with a
// transaction-level cache model predicting hit/miss, writebacks, latency and counters.
module tb_cache_control;

  logic       clk, rst;
  logic       mem_read, mem_write, mem_resp;
  logic       hit, valid_out, dirty_out;
  logic       pmem_read, pmem_write, pmem_resp, pmem_addr_sel;
  logic       data_sel, load_data, load_tag, load_valid, load_dirty, dirty_in;
  logic [3:0] hit_count, miss_count;

  cache_control #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit(hit), .valid_out(valid_out), .dirty_out(dirty_out),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .pmem_addr_sel(pmem_addr_sel), .data_sel(data_sel),
    .load_data(load_data), .load_tag(load_tag), .load_valid(load_valid),
    .load_dirty(load_dirty), .dirty_in(dirty_in),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Emulated storage arrays (the datapath side), updated only by the DUT's load strobes.
  logic       e_v [4];
  logic       e_d [4];
  logic [3:0] e_t [4];
  logic [1:0] cur_idx;
  logic [3:0] cur_tag;
  logic       clr;

  assign hit       = e_v[cur_idx] && (e_t[cur_idx] == cur_tag);
  assign valid_out = e_v[cur_idx];
  assign dirty_out = e_d[cur_idx];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4; i++) begin
        e_v[i] <= 1'b0;
        e_d[i] <= 1'b0;
        e_t[i] <= 4'h0;
      end
    end else begin
      if (load_tag)   e_t[cur_idx] <= cur_tag;
      if (load_valid) e_v[cur_idx] <= 1'b1;
      if (load_dirty) e_d[cur_idx] <= dirty_in;
    end
  end

  // Reference cache state, kept per transaction.
  bit       r_v [4];
  bit       r_d [4];
  bit [3:0] r_t [4];
  int       r_hit, r_miss;
  int       checks, errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input bit wr, input bit both, input logic [1:0] idx, input logic [3:0] tag,
                     input int rdl, input int wrl, input bit drop, input string nm);
    bit exp_hit, exp_wb, resp_seen, fill_seen, fill_ok, wl_ok, bad;
    int exp_lat, rdc, wrc, n, resp_n, fill_n;
    exp_hit = r_v[idx] && (r_t[idx] == tag);
    exp_wb  = !exp_hit && r_v[idx] && r_d[idx];
    exp_lat = exp_hit ? 2 : 3 + rdl + (exp_wb ? wrl : 0);
    cur_idx = idx; cur_tag = tag;
    mem_write = wr; mem_read = !wr || both;
    pmem_resp = 1'b0;
    resp_seen = 0; fill_seen = 0; fill_ok = 1; wl_ok = 1; bad = 0;
    rdc = 0; wrc = 0; n = 0; resp_n = 0; fill_n = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk); n++; pmem_resp = 1'b0; #1;
      if (pmem_read && pmem_write) bad = 1;
      if (pmem_write) begin
        wrc++;
        if (!pmem_addr_sel || rdc > 0) bad = 1;
        if (wrc == wrl) pmem_resp = 1'b1;
      end
      if (pmem_read) begin
        rdc++;
        if (pmem_addr_sel) bad = 1;
        if (rdc == rdl) pmem_resp = 1'b1;
        if (drop && rdc == 1) begin mem_read = 1'b0; mem_write = 1'b0; end
      end
      #1;
      if (pmem_resp && pmem_read) begin
        fill_seen = 1; fill_n = n;
        if (!(load_data && data_sel && load_tag && load_valid && load_dirty && !dirty_in)) fill_ok = 0;
      end else if (load_tag || load_valid) bad = 1;
      if (mem_resp) begin
        resp_seen = 1; resp_n = n;
        if (wr) begin
          if (!(load_data && !data_sel && load_dirty && dirty_in)) wl_ok = 0;
        end else if (load_data || load_dirty) wl_ok = 0;
        break;
      end
      if (drop && fill_seen && n == fill_n + 1) break;
    end
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    #1;
    if (exp_hit) begin
      if (wr) r_d[idx] = 1;
      if (r_hit < 15) r_hit++;
    end else begin
      if (r_miss < 15) r_miss++;
      r_v[idx] = 1; r_t[idx] = tag; r_d[idx] = wr && !drop;
    end
    if (drop) chk({nm, "_no_resp"}, resp_seen, 1'b0);
    else begin
      chk({nm, "_resp"}, resp_seen, 1'b1);
      chk({nm, "_lat"}, resp_n + 1, exp_lat);
      chk({nm, "_wrloads"}, wl_ok, 1'b1);
    end
    chk({nm, "_wb_cycles"}, wrc, exp_wb ? wrl : 0);
    chk({nm, "_rd_cycles"}, rdc, exp_hit ? 0 : rdl);
    chk({nm, "_fill"}, fill_seen, !exp_hit);
    chk({nm, "_fill_loads"}, fill_ok, 1'b1);
    chk({nm, "_protocol"}, bad, 1'b0);
    chk({nm, "_resp_pulse"}, mem_resp, 1'b0);
    chk({nm, "_hits"}, hit_count, r_hit);
    chk({nm, "_misses"}, miss_count, r_miss);
  endtask

  initial begin
    logic [1:0] ri;
    logic [3:0] rt;
    int rdc, wrc;
    checks = 0; errors = 0; r_hit = 0; r_miss = 0;
    for (int i = 0; i < 4; i++) begin r_v[i] = 0; r_d[i] = 0; r_t[i] = 0; end
    rst = 1'b0; clr = 1'b1; pmem_resp = 1'b0;
    cur_idx = 2'd0; cur_tag = 4'h1; mem_read = 1'b1; mem_write = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_resp", mem_resp, 1'b0);
    chk("rst_pmem", {pmem_read, pmem_write, pmem_addr_sel}, 3'b000);
    chk("rst_loads", {load_data, load_tag, load_valid, load_dirty, dirty_in, data_sel}, 6'b0);
    chk("rst_counts", {hit_count, miss_count}, 8'h00);
    mem_read = 1'b0; rst = 1'b1; clr = 1'b0;
    @(negedge clk);

    txn(0, 0, 2'd0, 4'h1, 5, 1, 0, "t1_read_miss");
    txn(0, 0, 2'd0, 4'h1, 5, 1, 0, "t2_read_hit");
    txn(1, 0, 2'd0, 4'h1, 1, 1, 0, "t3_write_hit");
    txn(0, 0, 2'd0, 4'h2, 2, 3, 0, "t4_dirty_miss");

    for (int i = 0; i < 20; i++) begin
      ri = 2'($urandom_range(0, 3)); rt = 4'($urandom_range(0, 3));
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ri, rt,
          $urandom_range(1, 4), $urandom_range(1, 4), 0, "rand_a");
    end

    while (r_hit < 15) txn(0, 0, 2'd0, 4'h2, 1, 1, 0, "t5_fill_hits");
    txn(0, 0, 2'd0, 4'h2, 1, 1, 0, "t5_sat_hit");
    chk("t5_hit_saturated", hit_count, 4'hF);

    ri = 2'd1; rt = r_t[1] + 4'h1;
    txn(1, 0, ri, rt, 3, 2, 1, "drop_mid_miss");
    txn(0, 0, ri, rt, 3, 2, 0, "drop_then_hit");

    // Reset in the middle of a line fill.
    ri = 2'd2; rt = r_t[2] + 4'h1;
    cur_idx = ri; cur_tag = rt; mem_read = 1'b1; mem_write = 1'b0;
    rdc = 0; wrc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); pmem_resp = 1'b0; #1;
      if (pmem_write) begin wrc++; pmem_resp = 1'b1; end
      if (pmem_read) rdc++;
      if (rdc == 2) break;
    end
    chk("t6_reached_allocate", rdc, 2);
    rst = 1'b0; pmem_resp = 1'b1; #1;
    chk("t6_pmem_drop", {pmem_read, pmem_write}, 2'b00);
    chk("t6_no_load", {load_data, load_tag, load_valid, load_dirty}, 4'b0000);
    chk("t6_counts", {hit_count, miss_count}, 8'h00);
    @(negedge clk); #1;
    chk("t6_no_load_edge", {load_data, load_tag, load_valid, load_dirty, mem_resp}, 5'b0);
    mem_read = 1'b0; pmem_resp = 1'b0; rst = 1'b1;
    r_hit = 0; r_miss = 0;
    @(negedge clk);
    txn(0, 0, ri, rt, 2, 2, 0, "t6_retry_misses");

    for (int i = 0; i < 30; i++) begin
      ri = 2'($urandom_range(0, 3)); rt = 4'($urandom_range(0, 2));
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ri, rt,
          $urandom_range(1, 3), $urandom_range(1, 3), 0, "rand_b");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
